// File: rtl/button_debounce_ctrl_if.sv
// Button control bundle: enable and raw pin in, debounced level and strobes out.
interface button_debounce_ctrl_if;
  logic ena;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;

  modport master (
    output ena,
    output btn_in,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse
  );

  modport slave (
    input  ena,
    input  btn_in,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output long_pulse
  );
endinterface

// File: rtl/button_debounce_ctrl.sv
// Debounces one push-button and emits a clean level plus single-cycle
// press, release and long-press strobes for the seconds counter.
module button_debounce_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 10000,
  parameter int unsigned LONG_CYCLES     = 10000000,
  parameter bit          ACTIVE_HIGH     = 1'b1
) (
  input logic                   clk,
  input logic                   rst_n,
  button_debounce_ctrl_if.slave bus
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW = (LONG_CYCLES == 0) ? 1 : $clog2(LONG_CYCLES + 1);
  // The state is entered on the first stable sample, so acceptance happens
  // DEBOUNCE_CYCLES-2 increments later.
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 2);
  localparam logic [HW-1:0] HCNT_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_CYCLES - 1);
  localparam bit            LONG_EN   = (LONG_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } state_e;

  state_e          state_q;
  logic [1:0]      sync_q;
  logic [DW-1:0]   dcnt_q;
  logic [HW-1:0]   hcnt_q;
  logic            long_done_q;
  logic            level_q;
  logic            press_q;
  logic            release_q;
  logic            long_q;
  logic            btn_norm_s;
  logic            raw_s;

  assign btn_norm_s = ACTIVE_HIGH ? bus.btn_in : ~bus.btn_in;
  assign raw_s      = sync_q[1];

  // Synchroniser runs regardless of ena so a held button is seen at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_norm_s};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dcnt_q      <= '0;
      hcnt_q      <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else if (!bus.ena) begin
      state_q     <= IDLE;
      dcnt_q      <= '0;
      hcnt_q      <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (raw_s) begin
            state_q <= DB_PRESS;
            dcnt_q  <= '0;
          end
        end
        DB_PRESS: begin
          if (!raw_s) begin
            state_q <= IDLE;
          end else if (dcnt_q == DB_LAST) begin
            state_q     <= PRESSED;
            press_q     <= 1'b1;
            level_q     <= 1'b1;
            hcnt_q      <= '0;
            long_done_q <= 1'b0;
          end else begin
            dcnt_q <= dcnt_q + DW'(1);
          end
        end
        PRESSED: begin
          // A falling raw input wins; the hold count does not advance that cycle.
          if (!raw_s) begin
            state_q <= DB_RELEASE;
            dcnt_q  <= '0;
          end else if (LONG_EN && (hcnt_q != HCNT_MAX)) begin
            hcnt_q <= hcnt_q + HW'(1);
            if ((hcnt_q == HCNT_LAST) && !long_done_q) begin
              long_q      <= 1'b1;
              long_done_q <= 1'b1;
            end
          end
        end
        DB_RELEASE: begin
          if (raw_s) begin
            state_q <= PRESSED;
          end else if (dcnt_q == DB_LAST) begin
            state_q   <= IDLE;
            release_q <= 1'b1;
            level_q   <= 1'b0;
          end else begin
            dcnt_q <= dcnt_q + DW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          dcnt_q  <= '0;
          hcnt_q  <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_pulse    = long_q;

endmodule

// File: tb/tb_button_debounce_ctrl.sv
// Directed bench for button_debounce_ctrl with DEBOUNCE_CYCLES=8, LONG_CYCLES=32.
module tb_button_debounce_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  button_debounce_ctrl_if bus_a ();
  button_debounce_ctrl_if bus_b ();

  button_debounce_ctrl #(.DEBOUNCE_CYCLES(8), .LONG_CYCLES(32), .ACTIVE_HIGH(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  button_debounce_ctrl #(.DEBOUNCE_CYCLES(8), .LONG_CYCLES(32), .ACTIVE_HIGH(1'b0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int press_n, release_n, long_n, press_at, release_at, long_at;
  int multi_n, level_seen, press2_n, press2_at;
  int t0, t1, t2;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    press_n = 0; release_n = 0; long_n = 0;
    press_at = -1; release_at = -1; long_at = -1;
    level_seen = 0; press2_n = 0; press2_at = -1;
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus_a.press_pulse)   begin press_n++;   press_at = cyc;   end
    if (bus_a.release_pulse) begin release_n++; release_at = cyc; end
    if (bus_a.long_pulse)    begin long_n++;    long_at = cyc;    end
    if ((32'(bus_a.press_pulse) + 32'(bus_a.release_pulse) + 32'(bus_a.long_pulse)) > 1) multi_n++;
    if (bus_a.btn_level) level_seen = 1;
    if (bus_b.press_pulse) begin press2_n++; press2_at = cyc; end
  endtask

  task automatic drive(input int n, input logic b);
    bus_a.btn_in = b;
    repeat (n) step();
  endtask

  initial begin
    multi_n = 0;
    clear_stats();
    rst_n = 1'b0;
    bus_a.ena = 1'b1; bus_a.btn_in = 1'b0;
    bus_b.ena = 1'b1; bus_b.btn_in = 1'b1;
    #12;
    check_eq("rst_level",   32'(bus_a.btn_level), 0);
    check_eq("rst_press",   32'(bus_a.press_pulse), 0);
    check_eq("rst_release", 32'(bus_a.release_pulse), 0);
    check_eq("rst_long",    32'(bus_a.long_pulse), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4, 1'b0);

    // 1: clean press and release
    clear_stats(); t0 = cyc;
    drive(20, 1'b1);
    check_eq("t1_level_held", 32'(bus_a.btn_level), 1);
    check_eq("t1_press_lat", press_at - t0, 10);
    t1 = cyc;
    drive(20, 1'b0);
    check_eq("t1_release_lat", release_at - t1, 10);
    check_eq("t1_press_n", press_n, 1);
    check_eq("t1_release_n", release_n, 1);
    check_eq("t1_long_n", long_n, 0);
    check_eq("t1_level_end", 32'(bus_a.btn_level), 0);

    // 2: bounce never stable long enough
    clear_stats();
    repeat (12) begin
      drive(5, 1'b1);
      drive(3, 1'b0);
    end
    drive(12, 1'b0);
    check_eq("t2_press_n", press_n, 0);
    check_eq("t2_release_n", release_n, 0);
    check_eq("t2_long_n", long_n, 0);
    check_eq("t2_level", level_seen, 0);

    // 3: long press
    clear_stats(); t0 = cyc;
    drive(60, 1'b1);
    check_eq("t3_press_lat", press_at - t0, 10);
    check_eq("t3_long_lat", long_at - press_at, 32);
    check_eq("t3_long_n", long_n, 1);
    t1 = cyc;
    drive(20, 1'b0);
    check_eq("t3_release_lat", release_at - t1, 10);
    check_eq("t3_release_n", release_n, 1);

    // 4: release glitch during hold; hold count frozen for 4 cycles
    clear_stats(); t0 = cyc;
    drive(20, 1'b1);
    drive(3, 1'b0);
    drive(40, 1'b1);
    check_eq("t4_press_n", press_n, 1);
    check_eq("t4_release_n_glitch", release_n, 0);
    check_eq("t4_long_lat", long_at - t0, 46);
    check_eq("t4_long_n", long_n, 1);
    t1 = cyc;
    drive(20, 1'b0);
    check_eq("t4_release_lat", release_at - t1, 10);
    check_eq("t4_press_n_end", press_n, 1);

    // 5: ena drop while pressed, then re-enable with button held
    clear_stats(); t0 = cyc;
    drive(20, 1'b1);
    check_eq("t5_press_n", press_n, 1);
    bus_a.ena = 1'b0;
    drive(1, 1'b1);
    check_eq("t5_level_off", 32'(bus_a.btn_level), 0);
    drive(5, 1'b1);
    check_eq("t5_no_release", release_n, 0);
    bus_a.ena = 1'b1;
    t2 = cyc;
    drive(12, 1'b1);
    check_eq("t5_repress_lat", press_at - t2, 8);
    check_eq("t5_press_n2", press_n, 2);
    drive(20, 1'b0);
    check_eq("t5_release_n", release_n, 1);

    // 6: async reset in DB_PRESS and in PRESSED; active-low instance
    clear_stats();
    drive(5, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_dbp_level", 32'(bus_a.btn_level), 0);
    check_eq("t6_rst_dbp_press", 32'(bus_a.press_pulse), 0);
    #2 rst_n = 1'b1;
    t1 = cyc;
    bus_b.btn_in = 1'b0;
    drive(20, 1'b1);
    check_eq("t6_press_lat", press_at - t1, 10);
    check_eq("t6_ah0_press_lat", press2_at - t1, 10);
    check_eq("t6_ah0_press_n", press2_n, 1);
    check_eq("t6_level_pre", 32'(bus_a.btn_level), 1);
    #3 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_async_level", 32'(bus_a.btn_level), 0);
    #2 rst_n = 1'b1;
    bus_b.btn_in = 1'b1;
    drive(20, 1'b0);
    check_eq("t6_release_n", release_n, 0);
    check_eq("t6_press_n", press_n, 1);

    check_eq("one_strobe_max", multi_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
